// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle.
// Groups everything if_stage exchanges with instruction memory, the hazard
// unit and the decode stage. clk and reset stay plain module ports.
//   slave  : the fetch stage itself.
//            Inputs:  InstrF, PCBranchD, PCSrcD, StallF, StallD, FlushD.
//            Outputs: PCF, PCPlus4F, InstrD, PCPlus4D, ValidD.
//   master : the environment around the fetch stage, which drives the
//            stage inputs and observes its outputs.
interface if_stage_if #(
  parameter int PC_WIDTH    = 9,
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] InstrF;
  logic [PC_WIDTH-1:0]    PCBranchD;
  logic                   PCSrcD;
  logic                   StallF;
  logic                   StallD;
  logic                   FlushD;
  logic [PC_WIDTH-1:0]    PCF;
  logic [PC_WIDTH-1:0]    PCPlus4F;
  logic [INSTR_WIDTH-1:0] InstrD;
  logic [PC_WIDTH-1:0]    PCPlus4D;
  logic                   ValidD;

  modport slave (
    input  InstrF, PCBranchD, PCSrcD, StallF, StallD, FlushD,
    output PCF, PCPlus4F, InstrD, PCPlus4D, ValidD
  );

  modport master (
    output InstrF, PCBranchD, PCSrcD, StallF, StallD, FlushD,
    input  PCF, PCPlus4F, InstrD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Holds the PC and computes PC+4. It picks the next PC, either sequential or
// the decode-stage branch target. It also registers the fetched instruction,
// PC+4 and a valid flag into the IF/ID pipeline register.
// Ports:
//   clk   : rising-edge clock.
//   reset : asynchronous, active-low. Asserting it clears all state at once.
//   bus   : if_stage_if.slave, which carries:
//           InstrF, PCBranchD, PCSrcD     fetch data and branch redirect.
//           StallF, StallD, FlushD        hazard-unit controls.
//           PCF, PCPlus4F                 current fetch address and PCF+4.
//           InstrD, PCPlus4D, ValidD      IF/ID register outputs.
module if_stage #(
  parameter int          PC_WIDTH    = 9,
  parameter int          INSTR_WIDTH = 32,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic     clk,
  input  logic     reset,
  if_stage_if.slave bus
);

  // Low bits are masked so that a misaligned parameter still yields a
  // word-aligned fetch address.
  localparam logic [PC_WIDTH-1:0] RESET_PC_W =
    {PC_WIDTH'(RESET_PC) >> 2, 2'b00};

  logic [PC_WIDTH-1:0]    pc_reg;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    pc_sel;
  logic [PC_WIDTH-1:0]    pc_next;
  logic [INSTR_WIDTH-1:0] instr_reg;
  logic [PC_WIDTH-1:0]    pcplus4_reg;
  logic                   valid_reg;

  // The sum wraps modulo 2^PC_WIDTH.
  assign pc_plus4 = pc_reg + PC_WIDTH'(4);
  assign pc_sel   = bus.PCSrcD ? bus.PCBranchD : pc_plus4;
  // Branch targets are forced to word alignment.
  assign pc_next  = {pc_sel[PC_WIDTH-1:2], 2'b00};

  // PC register: a stall holds the PC. A redirect seen during a stall is
  // dropped; the hazard unit keeps PCSrcD high until the stall clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC_W;
    end else if (!bus.StallF) begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID register: a flush beats a stall and inserts an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_reg   <= '0;
      pcplus4_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (bus.FlushD) begin
      instr_reg   <= '0;
      pcplus4_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (!bus.StallD) begin
      instr_reg   <= bus.InstrF;
      pcplus4_reg <= pc_plus4;
      valid_reg   <= 1'b1;
    end
  end

  assign bus.PCF      = pc_reg;
  assign bus.PCPlus4F = pc_plus4;
  assign bus.InstrD   = instr_reg;
  assign bus.PCPlus4D = pcplus4_reg;
  assign bus.ValidD   = valid_reg;

endmodule
